stream_demux1x2: RTL

- 1-to-2 stream demultiplexer: routes packets on one 8-bit valid/ready input stream to one of two output streams.
- The route is chosen by `sel` at the first beat of each packet and held until the last beat.
- Each output is registered through a 2-entry skid buffer, so `s_ready` has no combinational path from `m*_ready`.
- Sits on the datapath side opposite the 2:1 mux: it fans a shared 8-bit channel back out to two consumers.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_skid_buf.sv | 74 +++++++
 rtl/stream_demux1x2.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and default widths for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } demux_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/stream_demux_skid_buf.sv
// Two-entry registered valid/ready buffer: an output slot plus a skid slot
// that catches the beat in flight when the consumer stops accepting.
module skid_buf
  import stream_demux_pkg::*;
#(
  parameter type beat_type_t = beat_t
) (
  input  logic       clk,
  input  logic       reset_n,
  input  beat_type_t push_beat_i,
  input  logic       push_i,
  output logic       full_o,
  output beat_type_t out_beat_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  beat_type_t out_q, out_d;
  beat_type_t skid_q, skid_d;
  logic       out_vld_q, out_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic       pop;

  // Slot bookkeeping; the skid slot is only ever occupied behind the output slot.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    pop        = out_vld_q && out_ready_i;
    if (pop) begin
      if (skid_vld_q) begin
        out_d = skid_q;
        if (push_i) begin
          skid_d = push_beat_i;
        end else begin
          skid_vld_d = 1'b0;
        end
      end else if (push_i) begin
        out_d = push_beat_i;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push_i) begin
      if (out_vld_q) begin
        skid_d     = push_beat_i;
        skid_vld_d = 1'b1;
      end else begin
        out_d     = push_beat_i;
        out_vld_d = 1'b1;
      end
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign full_o      = skid_vld_q;
  assign out_beat_o  = out_q;
  assign out_valid_o = out_vld_q;

endmodule

// File: rtl/stream_demux1x2.sv
// 1-to-2 packet demultiplexer: route chosen by sel on a packet's first beat,
// each output decoupled through its own skid buffer.
module stream_demux1x2
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              sel,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_valid,
  output logic              m0_last,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_valid,
  output logic              m1_last,
  input  logic              m1_ready,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              busy
);

  // Same layout as beat_t, sized by this instance's DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } chan_beat_t;

  demux_state_t state_q, state_d;
  logic         route_q, route_d;
  logic         ready_en_q;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic       tgt;
  logic       accept;
  logic       full0, full1;
  logic       push0, push1;
  chan_beat_t in_beat, out0, out1;

  // Target channel and ready steering; only the target's full flag matters.
  always_comb begin
    tgt     = (state_q == IDLE) ? sel : route_q;
    s_ready = ready_en_q && !(tgt ? full1 : full0);
    accept  = s_valid && s_ready;
    push0   = accept && !tgt;
    push1   = accept && tgt;
    in_beat = '{data: s_data, last: s_last};
  end

  // Packet FSM and delivered-packet counters.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!s_last) begin
            route_d = sel;
            state_d = ROUTE;
          end
        end
        ROUTE: begin
          if (s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (m0_valid && m0_ready && m0_last) cnt0_d = cnt0_q + CNT_W'(1);
    if (m1_valid && m1_ready && m1_last) cnt1_d = cnt1_q + CNT_W'(1);
  end

  // State, route and counter registers; ready_en_q holds s_ready low until
  // the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      route_q    <= 1'b0;
      ready_en_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      ready_en_q <= 1'b1;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  skid_buf #(.beat_type_t(chan_beat_t)) u_buf0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_beat_i (in_beat),
    .push_i      (push0),
    .full_o      (full0),
    .out_beat_o  (out0),
    .out_valid_o (m0_valid),
    .out_ready_i (m0_ready)
  );

  skid_buf #(.beat_type_t(chan_beat_t)) u_buf1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_beat_i (in_beat),
    .push_i      (push1),
    .full_o      (full1),
    .out_beat_o  (out1),
    .out_valid_o (m1_valid),
    .out_ready_i (m1_ready)
  );

  assign m0_data  = out0.data;
  assign m0_last  = out0.last;
  assign m1_data  = out1.data;
  assign m1_last  = out1.last;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
  assign busy     = (state_q == ROUTE);

endmodule
